uart_tx_mmio: RTL and testbench

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

---
 rtl/uart_tx_mmio.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with a byte FIFO and programmable baud divisor.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_ce,
    input  logic        ram_wr_en,
    input  logic [31:0] ram_addr,
    input  logic [3:0]  ram_addr_sel,
    input  logic [31:0] ram_wr_data,
    output logic [31:0] ram_data_in,
    output logic        uart_txd,
    output logic        tx_irq
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state_q, state_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty;

    logic [15:0]   div;
    logic [15:0]   cnt;
    logic [15:0]   reload;
    logic          bit_end;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          ovf;
    logic          pop;

`ifdef UART_TX_PARITY_EN
    logic          par;
`endif

    logic [1:0]    addr;
    logic          push_req, push_ok, baud_wr, status_rd;
    logic          unused_ok;

    assign unused_ok = ^{ram_addr[31:4], ram_addr[1:0], ram_wr_data[31:16]};

    assign addr      = ram_addr[3:2];
    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign push_req  = ram_ce & ram_wr_en & (addr == 2'd0) & ram_addr_sel[0];
    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    assign push_ok   = push_req & (~full | pop);
    assign baud_wr   = ram_ce & ram_wr_en & (addr == 2'd2);
    assign status_rd = ram_ce & ~ram_wr_en & (addr == 2'd1);

    // A divisor of zero behaves like one cycle per bit.
    assign reload  = (div == 16'd0) ? 16'd0 : div - 16'd1;
    assign bit_end = (cnt == 16'd0);
    assign tx_irq  = empty & (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d = START;
                    pop     = 1'b1;
                end
            end
            START: if (bit_end) state_d = DATA;
            DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        state_d = START;
                        pop     = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        uart_txd = 1'b1;
        case (state_q)
            START:   uart_txd = 1'b0;
            DATA:    uart_txd = shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  uart_txd = par;
`endif
            default: uart_txd = 1'b1;
        endcase
    end

    // rst_n is an active-high reset in this block.
    always_ff @(posedge clk) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= ram_wr_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            div    <= DIV_RESET;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) ovf <= 1'b1;
            else if (status_rd)       ovf <= 1'b0;
            if (baud_wr && ram_addr_sel[0]) div[7:0]  <= ram_wr_data[7:0];
            if (baud_wr && ram_addr_sel[1]) div[15:8] <= ram_wr_data[15:8];
        end
    end

    // Bit timing: the counter reloads on every boundary, so divisor changes land on the next bit.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else if (pop) begin
            cnt     <= reload;
            bit_idx <= 3'd0;
            shreg   <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            par     <= ^mem[rd_ptr];
`endif
        end else if (state_q != IDLE) begin
            if (bit_end) begin
                cnt <= reload;
                if (state_q == DATA) begin
                    shreg   <= {1'b0, shreg[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                cnt <= cnt - 16'd1;
            end
        end
    end

    always_comb begin
        ram_data_in = 32'd0;
        if (!rst_n && ram_ce && !ram_wr_en) begin
            case (addr)
                2'd1:    ram_data_in = {28'd0, ovf, (state_q != IDLE), empty, full};
                2'd2:    ram_data_in = {16'd0, div};
                default: ram_data_in = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - table-driven register checks plus directed serial-frame sequences.
module tb_uart_tx_mmio;

`ifdef UART_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int NCAP = 2 + 20 * F + 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ram_ce;
    logic        ram_wr_en;
    logic [31:0] ram_addr;
    logic [3:0]  ram_addr_sel;
    logic [31:0] ram_wr_data;
    logic [31:0] ram_data_in;
    logic        uart_txd;
    logic        tx_irq;

    int n_vec = 0;
    int n_bad = 0;

    logic cap_on = 1'b0;
    int   cap_n;
    logic cap_buf [0:511];

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [3:0]  sel;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [18];

    uart_tx_mmio #(.FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ram_ce       (ram_ce),
        .ram_wr_en    (ram_wr_en),
        .ram_addr     (ram_addr),
        .ram_addr_sel (ram_addr_sel),
        .ram_wr_data  (ram_wr_data),
        .ram_data_in  (ram_data_in),
        .uart_txd     (uart_txd),
        .tx_irq       (tx_irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_on) begin
            if (cap_n < 512) cap_buf[cap_n] <= uart_txd;
            cap_n <= cap_n + 1;
        end else begin
            cap_n <= 0;
        end
    end

    function automatic vec_t mk(input logic wr, input logic [1:0] a, input logic [3:0] sel,
                                input logic [31:0] d, input logic [31:0] exp);
        vec_t v;
        v.wr = wr; v.a = a; v.sel = sel; v.d = d; v.exp = exp;
        return v;
    endfunction

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        ram_ce = 1'b0; ram_wr_en = 1'b0; ram_addr = 32'd0; ram_addr_sel = 4'd0; ram_wr_data = 32'd0;
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [3:0] s, input logic [31:0] d);
        ram_ce = 1'b1; ram_wr_en = 1'b1; ram_addr = {28'd0, a, 2'b00}; ram_addr_sel = s; ram_wr_data = d;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic bus_rd(input logic [1:0] a, output logic [31:0] d);
        ram_ce = 1'b1; ram_wr_en = 1'b0; ram_addr = {28'd0, a, 2'b00}; ram_addr_sel = 4'd0;
        #1 d = ram_data_in;
        @(negedge clk);
        bus_idle();
    endtask

    // Call right after the TXDATA write returns; div 0 behaves as one cycle per bit.
    task automatic check_frame(input string nm, input logic [7:0] b, input int d);
        int de;
        de = (d == 0) ? 1 : d;
        for (int j = 1; j <= F * de; j++) begin
            @(negedge clk);
            chk1($sformatf("%s_s%0d", nm, j), uart_txd, frame_bit(b, (j - 1) / de));
        end
        @(negedge clk);
        chk1({nm, "_idle_txd"}, uart_txd, 1'b1);
        chk1({nm, "_idle_irq"}, tx_irq, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        logic [7:0]  bq [10];

        tbl[0]  = mk(1'b0, 2'd1, 4'h0, 32'h0,        32'h2);
        tbl[1]  = mk(1'b0, 2'd2, 4'h0, 32'h0,        32'h364);
        tbl[2]  = mk(1'b0, 2'd3, 4'h0, 32'h0,        32'h0);
        tbl[3]  = mk(1'b0, 2'd0, 4'h0, 32'h0,        32'h0);
        tbl[4]  = mk(1'b1, 2'd2, 4'h3, 32'h0868,     32'h0);
        tbl[5]  = mk(1'b0, 2'd2, 4'h0, 32'h0,        32'h0868);
        tbl[6]  = mk(1'b1, 2'd2, 4'h1, 32'h1234,     32'h0);
        tbl[7]  = mk(1'b0, 2'd2, 4'h0, 32'h0,        32'h0834);
        tbl[8]  = mk(1'b1, 2'd2, 4'h2, 32'hAB00,     32'h0);
        tbl[9]  = mk(1'b0, 2'd2, 4'h0, 32'h0,        32'hAB34);
        tbl[10] = mk(1'b1, 2'd3, 4'hF, 32'hFFFFFFFF, 32'h0);
        tbl[11] = mk(1'b0, 2'd3, 4'h0, 32'h0,        32'h0);
        tbl[12] = mk(1'b1, 2'd2, 4'hC, 32'hFFFFFFFF, 32'h0);
        tbl[13] = mk(1'b0, 2'd2, 4'h0, 32'h0,        32'hAB34);
        tbl[14] = mk(1'b1, 2'd0, 4'h0, 32'hAA,       32'h0);
        tbl[15] = mk(1'b0, 2'd1, 4'h0, 32'h0,        32'h2);
        tbl[16] = mk(1'b1, 2'd2, 4'h3, 32'h4,        32'h0);
        tbl[17] = mk(1'b0, 2'd2, 4'h0, 32'h0,        32'h4);

        for (int i = 0; i < 10; i++) bq[i] = 8'((i * 29 + 3) & 255);

        // Reset state
        rst_n = 1'b1;
        bus_idle();
        repeat (3) @(negedge clk);
        ram_ce = 1'b1; ram_addr = 32'h8;
        #1 chk("rst_rdata", ram_data_in, 32'h0);
        chk1("rst_txd", uart_txd, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        bus_idle();
        #1 chk1("post_rst_irq", tx_irq, 1'b1);
        chk1("post_rst_txd", uart_txd, 1'b1);
        ram_ce = 1'b0; ram_wr_en = 1'b0; ram_addr = 32'h8;
        #1 chk("ce_low_rdata", ram_data_in, 32'h0);
        bus_idle();
        @(negedge clk);

        // Register map vectors
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].wr) begin
                bus_wr(tbl[i].a, tbl[i].sel, tbl[i].d);
            end else begin
                bus_rd(tbl[i].a, r);
                chk($sformatf("tbl%0d", i), r, tbl[i].exp);
            end
        end

        // Single frames at DIV=4
        bus_wr(2'd0, 4'h1, 32'h55);
        check_frame("f55", 8'h55, 4);
        bus_wr(2'd0, 4'h1, 32'hA3);
        check_frame("fA3", 8'hA3, 4);

        // Divisor change during START applies from the next bit
        bus_wr(2'd0, 4'h1, 32'hC6);
        @(negedge clk);
        chk1("bc_start0", uart_txd, 1'b0);
        bus_wr(2'd2, 4'h3, 32'h2);
        chk1("bc_start1", uart_txd, 1'b0);
        @(negedge clk);
        chk1("bc_start2", uart_txd, 1'b0);
        @(negedge clk);
        chk1("bc_start3", uart_txd, 1'b0);
        for (int t = 0; t < (F - 1) * 2; t++) begin
            @(negedge clk);
            chk1($sformatf("bc_s%0d", t), uart_txd, frame_bit(8'hC6, 1 + t / 2));
        end
        @(negedge clk);
        chk1("bc_idle_txd", uart_txd, 1'b1);
        chk1("bc_idle_irq", tx_irq, 1'b1);
        bus_wr(2'd2, 4'h3, 32'h4);

        // Reset during DATA bit 3 with a byte still queued
        bus_wr(2'd0, 4'h1, 32'hF0);
        bus_wr(2'd0, 4'h1, 32'h77);
        repeat (16) @(negedge clk);
        chk1("mid_bit3_txd", uart_txd, 1'b0);
        rst_n = 1'b1;
        ram_ce = 1'b1; ram_wr_en = 1'b0; ram_addr = 32'h4;
        #1 chk("mid_rst_rdata", ram_data_in, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        bus_idle();
        chk1("mid_rst_txd", uart_txd, 1'b1);
        chk1("mid_rst_irq", tx_irq, 1'b1);
        bus_rd(2'd1, r);
        chk("mid_rst_status", r, 32'h2);
        bus_rd(2'd2, r);
        chk("mid_rst_baud", r, 32'h364);

        // FIFO fill, overflow, and push on the STOP boundary while full (DIV=2)
        bus_wr(2'd2, 4'h3, 32'h2);
        @(posedge clk);
        #1 cap_on = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 9; i++) bus_wr(2'd0, 4'h1, {24'd0, bq[i]});
        bus_rd(2'd1, r);
        chk("fill_status", r, 32'h5);
        bus_wr(2'd0, 4'h1, 32'hEE);
        bus_rd(2'd1, r);
        chk("ovf_status", r, 32'hD);
        bus_rd(2'd1, r);
        chk("ovf_cleared", r, 32'h5);
        repeat (2 * F + 1 - 13) @(negedge clk);
        bus_wr(2'd0, 4'h1, {24'd0, bq[9]});
        bus_rd(2'd1, r);
        chk("stop_push_status", r, 32'h5);
        for (int w = 0; w < 2000 && cap_n < NCAP; w++) @(negedge clk);
        chk1("cap_done", cap_n >= NCAP, 1'b1);
        #1 cap_on = 1'b0;
        chk1("cap_pre0", cap_buf[0], 1'b1);
        chk1("cap_pre1", cap_buf[1], 1'b1);
        for (int t = 0; t < 20 * F; t++)
            chk1($sformatf("stream_s%0d", t), cap_buf[2 + t],
                 frame_bit(bq[t / (2 * F)], (t % (2 * F)) / 2));
        for (int t = 0; t < 4; t++)
            chk1($sformatf("stream_tail%0d", t), cap_buf[2 + 20 * F + t], 1'b1);
        @(negedge clk);
        chk1("drain_irq", tx_irq, 1'b1);
        bus_rd(2'd1, r);
        chk("drain_status", r, 32'h2);

        // DIV=0 gives one cycle per bit
        bus_wr(2'd2, 4'h3, 32'h0);
        bus_wr(2'd0, 4'h1, 32'h3C);
        check_frame("div0", 8'h3C, 0);
        bus_rd(2'd3, r);
        chk("addr3_read", r, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
